// File: rtl/sfifo_wr_arbiter.sv
// Round-robin packet write arbiter sharing one sfifo write port among NREQ producers.
// A grant is held for a whole packet; each beat is tagged with the source id.
module sfifo_wr_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 64,
    parameter int CNTW   = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ-1:0]                 req_last,
    input  logic [NREQ*DWIDTH-1:0]          req_data,
    output logic [NREQ-1:0]                 req_ready,
    output logic [DWIDTH+$clog2(NREQ)-1:0]  fifo_din,
    output logic                            fifo_wr_en,
    input  logic                            fifo_full,
    input  logic                            fifo_afull,
    output logic                            busy,
    output logic [$clog2(NREQ)-1:0]         grant_id,
    output logic [CNTW-1:0]                 pkt_count
);
    localparam int             IDW     = $clog2(NREQ);
    localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_reg, state_next;
    logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [IDW-1:0]  grant_id_reg, grant_id_next;
    logic [CNTW-1:0] pkt_count_reg, pkt_count_next;

    logic [DWIDTH-1:0] data_arr [NREQ];
    logic [2*NREQ-1:0] req_rot;
    logic [IDW-1:0]    off_chain [NREQ+1];
    logic [IDW:0]      win_sum;
    logic [IDW-1:0]    win_id;
    logic              arb_en;
    logic              locked;
    logic              gnt_valid;
    logic              gnt_last;
    logic              xfer;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*DWIDTH +: DWIDTH];
    end

    // Rotate requests so bit 0 is the rr_ptr requester; lowest set bit wins.
    assign req_rot = {req_valid, req_valid} >> rr_ptr_reg;

    assign off_chain[NREQ] = '0;
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_prio
        assign off_chain[gi] = req_rot[gi] ? IDW'(gi) : off_chain[gi+1];
    end

    assign win_sum = {1'b0, rr_ptr_reg} + {1'b0, off_chain[0]};
    assign win_id  = (win_sum >= NREQ_W) ? IDW'(win_sum - NREQ_W) : win_sum[IDW-1:0];

    assign arb_en    = (|req_valid) && !fifo_afull && !fifo_full;
    assign locked    = (state_reg == LOCKED);
    assign gnt_valid = req_valid[grant_id_reg];
    assign gnt_last  = req_last[grant_id_reg];
    assign xfer      = locked && gnt_valid && !fifo_full;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = locked && (grant_id_reg == IDW'(gi)) && !fifo_full;
    end

    assign fifo_wr_en = xfer;
    assign fifo_din   = {grant_id_reg, data_arr[grant_id_reg]};
    assign busy       = locked;
    assign grant_id   = grant_id_reg;
    assign pkt_count  = pkt_count_reg;

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_id_next  = grant_id_reg;
        pkt_count_next = pkt_count_reg;
        case (state_reg)
            IDLE: begin
                if (arb_en) begin
                    grant_id_next = win_id;
                    state_next    = LOCKED;
                end
            end
            LOCKED: begin
                // Last winner drops to lowest priority on packet completion.
                if (xfer && gnt_last) begin
                    state_next     = IDLE;
                    rr_ptr_next    = (grant_id_reg == LAST_ID) ? '0 : grant_id_reg + IDW'(1);
                    pkt_count_next = pkt_count_reg + CNTW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_id_reg  <= '0;
            pkt_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_id_reg  <= grant_id_next;
            pkt_count_reg <= pkt_count_next;
        end
    end

endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// Scoreboard bench for sfifo_wr_arbiter: per-requester packet drivers, expected
// FIFO writes queued at issue time, negedge monitor pops and compares.
module tb_sfifo_wr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int IDW  = 2;

    typedef struct {int len; int seq;} pkt_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    wire  [NREQ-1:0]     req_valid;
    wire  [NREQ-1:0]     req_last;
    wire  [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [DW+IDW-1:0]   fifo_din;
    logic                fifo_wr_en;
    logic                fifo_full = 1'b0;
    logic                fifo_afull = 1'b0;
    logic                busy;
    logic [IDW-1:0]      grant_id;
    logic [15:0]         pkt_count;

    // Second, non-power-of-two instance
    logic [2:0]  v3 = '0;
    logic [2:0]  l3 = '0;
    logic [23:0] d3 = '0;
    logic [2:0]  ready3;
    logic [9:0]  din3;
    logic        wr3;
    logic        full3 = 1'b0;
    logic        afull3 = 1'b0;
    logic        busy3;
    logic [1:0]  gid3;
    logic [15:0] cnt3;

    pkt_t              pq [NREQ][$];
    logic [DW+IDW-1:0] sb [$];
    logic [NREQ-1:0]   abort_req = '0;
    int n_chk = 0;
    int n_pass = 0;
    int seq_cnt = 0;

    sfifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .CNTW(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .fifo_afull(fifo_afull),
        .busy(busy), .grant_id(grant_id), .pkt_count(pkt_count)
    );

    sfifo_wr_arbiter #(.NREQ(3), .DWIDTH(8), .CNTW(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v3), .req_last(l3), .req_data(d3), .req_ready(ready3),
        .fifo_din(din3), .fifo_wr_en(wr3), .fifo_full(full3), .fifo_afull(afull3),
        .busy(busy3), .grant_id(gid3), .pkt_count(cnt3)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] beat_data(input int id, input int seq, input int b);
        return {8'(id), 24'(seq), 32'(b)};
    endfunction

    task automatic check(input bit ok, input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Queue a packet for requester id; expect its first n_exp beats in the FIFO.
    task automatic send(input int id, input int len, input int n_exp);
        seq_cnt++;
        pq[id].push_back('{len: len, seq: seq_cnt});
        for (int b = 0; b < n_exp; b++) sb.push_back({IDW'(id), beat_data(id, seq_cnt, b)});
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check(sb.size() == 0, name, 128'(sb.size()), 128'(0));
    endtask

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_drv
        logic          v_q = 1'b0;
        logic          l_q = 1'b0;
        logic [DW-1:0] d_q = '0;
        assign req_valid[gi]         = v_q;
        assign req_last[gi]          = l_q;
        assign req_data[gi*DW +: DW] = d_q;
        initial begin
            pkt_t cur;
            int   beat;
            bit   active;
            bit   hs;
            cur = '{len: 0, seq: 0};
            beat = 0;
            active = 1'b0;
            forever begin
                @(negedge clk);
                hs = v_q && req_ready[gi];
                @(posedge clk); #1;
                if (abort_req[gi]) begin
                    active = 1'b0;
                    pq[gi].delete();
                end else if (hs && active) begin
                    beat++;
                    if (beat == cur.len) active = 1'b0;
                end
                if (!active && !abort_req[gi] && pq[gi].size() != 0) begin
                    cur = pq[gi].pop_front();
                    beat = 0;
                    active = 1'b1;
                end
                v_q = active;
                l_q = active && (beat == cur.len - 1);
                d_q = active ? beat_data(gi, cur.seq, beat) : '0;
            end
        end
    end

    initial begin : monitor
        logic [DW+IDW-1:0] exp_v;
        forever begin
            @(negedge clk);
            if (fifo_wr_en === 1'b1) begin
                if (sb.size() == 0) begin
                    check(1'b0, "wr_unexpected", 128'(fifo_din), 128'(0));
                end else begin
                    exp_v = sb.pop_front();
                    check(fifo_din === exp_v, "wr_data", 128'(fifo_din), 128'(exp_v));
                end
            end
        end
    end

    initial begin : stim
        bit exp_pat [5];
        exp_pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        // Requesters 0, 2, 3 valid across reset exit: order 0, 2, 3
        send(0, 2, 2); send(2, 1, 1); send(3, 3, 3);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check(fifo_wr_en === 1'b0, "rst_wr_en", 128'(fifo_wr_en), 128'(0));
        check(req_ready === 4'b0, "rst_req_ready", 128'(req_ready), 128'(0));
        check(busy === 1'b0, "rst_busy", 128'(busy), 128'(0));
        check(pkt_count === 16'd0, "rst_pkt_count", 128'(pkt_count), 128'(0));
        check(grant_id === 2'd0, "rst_grant_id", 128'(grant_id), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        drain("round1_drain", 40);
        @(negedge clk); #1;
        check(pkt_count === 16'd3, "round1_pkt_count", 128'(pkt_count), 128'(3));

        // All four valid, rr_ptr wrapped to 0 after requester 3: order 0,1,2,3
        send(0, 1, 1); send(1, 1, 1); send(2, 1, 1); send(3, 1, 1);
        drain("round2_drain", 40);
        @(negedge clk); #1;
        check(pkt_count === 16'd7, "round2_pkt_count", 128'(pkt_count), 128'(7));

        // Requester 1, 3 beats: bubble, three writes, back to IDLE
        send(1, 3, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check(fifo_wr_en === exp_pat[i], "t3_wr_en", 128'(fifo_wr_en), 128'(exp_pat[i]));
            check(busy === exp_pat[i], "t3_busy", 128'(busy), 128'(exp_pat[i]));
        end
        check(pkt_count === 16'd8, "t3_pkt_count", 128'(pkt_count), 128'(8));
        drain("t3_drain", 5);

        // afull blocks the grant in IDLE; afull mid-packet does not stall
        fifo_afull = 1'b1;
        send(0, 4, 4);
        repeat (4) begin
            @(negedge clk); #1;
            check(req_ready === 4'b0, "afull_req_ready", 128'(req_ready), 128'(0));
            check(busy === 1'b0, "afull_busy", 128'(busy), 128'(0));
        end
        fifo_afull = 1'b0;
        @(negedge clk); #1;
        check(busy === 1'b1, "afull_drop_grant", 128'(busy), 128'(1));
        check(grant_id === 2'd0, "afull_grant_id", 128'(grant_id), 128'(0));
        fifo_afull = 1'b1;
        drain("afull_mid_drain", 6);
        fifo_afull = 1'b0;
        @(negedge clk); #1;
        check(pkt_count === 16'd9, "afull_pkt_count", 128'(pkt_count), 128'(9));

        // full on beat 2 of a 4-beat packet for 3 cycles
        send(2, 4, 4);
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            check(req_ready === 4'b0, "full_req_ready", 128'(req_ready), 128'(0));
            check(fifo_wr_en === 1'b0, "full_wr_en", 128'(fifo_wr_en), 128'(0));
        end
        fifo_full = 1'b0;
        drain("full_drain", 10);
        @(negedge clk); #1;
        check(pkt_count === 16'd10, "full_pkt_count", 128'(pkt_count), 128'(10));

        // Reset in the middle of a 5-beat packet, then resend
        send(1, 5, 3);
        drain("rst_mid_pre", 20);
        rst_n = 1'b0;
        abort_req[1] = 1'b1;
        @(negedge clk); #1;
        check(busy === 1'b0, "rst_mid_busy", 128'(busy), 128'(0));
        check(req_ready === 4'b0, "rst_mid_req_ready", 128'(req_ready), 128'(0));
        check(pkt_count === 16'd0, "rst_mid_pkt_count", 128'(pkt_count), 128'(0));
        check(grant_id === 2'd0, "rst_mid_grant_id", 128'(grant_id), 128'(0));
        rst_n = 1'b1;
        abort_req[1] = 1'b0;
        // rr_ptr back at 0: requester 1 beats requester 3
        send(1, 5, 5); send(3, 1, 1);
        drain("rst_mid_resend", 40);
        @(negedge clk); #1;
        check(pkt_count === 16'd2, "rst_mid_pkt_after", 128'(pkt_count), 128'(2));
        check(grant_id === 2'd3, "rst_mid_last_grant", 128'(grant_id), 128'(3));

        // NREQ=3: after requester 2 the pointer wraps to 0
        v3 = 3'b100; l3 = 3'b100; d3 = 24'hC2_00_00;
        @(negedge clk); #1;
        check(gid3 === 2'd2, "n3_grant2", 128'(gid3), 128'(2));
        check(wr3 === 1'b1, "n3_wr2", 128'(wr3), 128'(1));
        check(din3 === 10'h2C2, "n3_din2", 128'(din3), 128'(10'h2C2));
        v3 = 3'b101; l3 = 3'b101; d3 = 24'hC2_00_A0;
        @(negedge clk); #1;
        check(busy3 === 1'b0, "n3_bubble", 128'(busy3), 128'(0));
        check(cnt3 === 16'd1, "n3_count1", 128'(cnt3), 128'(1));
        @(negedge clk); #1;
        check(gid3 === 2'd0, "n3_wrap_grant", 128'(gid3), 128'(0));
        check(din3 === 10'h0A0, "n3_din0", 128'(din3), 128'(10'h0A0));
        @(posedge clk); #1;
        v3 = '0; l3 = '0; d3 = '0;
        @(negedge clk); #1;
        check(cnt3 === 16'd2, "n3_count2", 128'(cnt3), 128'(2));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sfifo_wr_arbiter.md
Name: sfifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO (the team's sfifo) between NREQ packet producers.
- Each producer presents valid/last/data beats. The arbiter grants one producer for a whole packet and forwards its beats to the FIFO write port, tagged with the source id.
- Flow control uses the FIFO's full and afull flags: a new packet starts only with afull headroom, and beats stall on full.
- Sits directly in front of sfifo; the FIFO read side is untouched.

Parameters:
NREQ, 4, number of requesters; integer >= 2. IDW = $clog2(NREQ) is derived locally.
DWIDTH, 64, payload width per beat.
CNTW, 16, width of the packets-forwarded counter.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
req_valid  input  NREQ  per-requester beat valid
req_last  input  NREQ  per-requester last beat of packet; qualified by req_valid
req_data  input  NREQ*DWIDTH  per-requester payload; requester i occupies bits [i*DWIDTH +: DWIDTH]
req_ready  output  NREQ  per-requester beat accepted this cycle when high with req_valid
fifo_din  output  DWIDTH+IDW  {grant_id, granted payload}; connects to sfifo din
fifo_wr_en  output  1  FIFO write strobe
fifo_full  input  1  sfifo full
fifo_afull  input  1  sfifo afull
busy  output  1  high while a packet is locked (LOCKED state)
grant_id  output  IDW  currently/last granted requester
pkt_count  output  CNTW  packets forwarded since reset; wraps modulo 2^CNTW

Behaviour:
- Reset (clk edge with rst_n=0): state=IDLE, rr_ptr=0, grant_id=0, pkt_count=0. Outputs are req_ready=0, fifo_wr_en=0, busy=0.
- Reset mid-packet aborts the packet. Beats already written stay in the FIFO; the requester must resend the whole packet.
- States: IDLE, LOCKED.
- IDLE arbitration:
  - Arbitration is enabled when any req_valid is set AND fifo_afull=0 AND fifo_full=0.
  - Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Next edge: grant_id <= winner, state <= LOCKED.
  - No beat transfers in IDLE: req_ready=0, fifo_wr_en=0. This costs exactly one bubble cycle per packet.
- IDLE with fifo_afull=1 or fifo_full=1: no grant. Stay in IDLE, rr_ptr unchanged.
- LOCKED handshake:
  - req_ready[grant_id] = ~fifo_full. All other req_ready bits = 0.
  - xfer = req_valid[grant_id] & ~fifo_full.
  - fifo_wr_en = xfer. fifo_din = {grant_id, req_data[grant_id]}.
  - Both outputs are combinational: zero-cycle latency from request to FIFO write port.
- LOCKED ignores fifo_afull. A locked packet continues until full and stalls only on fifo_full. Producers must keep packet lengths within the headroom AFULL provides.
- Absent beats: req_valid[grant_id]=0 in LOCKED means wait. The grant is held indefinitely; there is no timeout.
- Last beat (xfer & req_last[grant_id]), on the next edge:
  - state <= IDLE.
  - rr_ptr <= grant_id+1, wrapping NREQ-1 -> 0.
  - pkt_count <= pkt_count+1.
- Single-beat packet: valid and last together on the first LOCKED beat; it completes in one LOCKED cycle.
- Simultaneous requests resolve strictly by rr_ptr order. The last winner becomes lowest priority, so no requester starves while others keep requesting.
- grant_id holds its value in IDLE. busy = (state==LOCKED).
- Width rules:
  - rr_ptr and grant_id are IDW bits; wrap is explicit compare-to-NREQ-1, so it is correct for non-power-of-two NREQ.
  - pkt_count wraps naturally.
- req_last with req_valid=0 is ignored. Inputs of non-granted requesters are ignored.

Test Plan:
- Requester 1 sends a 3-beat packet D0..D2, FIFO empty:
  - Cycle 0: IDLE grant. Cycles 1-3: fifo_wr_en=1 with fifo_din={2'd1,Dn}.
  - Cycle 4: IDLE. pkt_count=1, rr_ptr=2.
- Requesters 0, 2 and 3 all valid at reset exit:
  - Grant order is 0, 2, 3, each separated by an IDLE bubble.
  - A second round with all four valid grants in order 0, 1, 2, 3.
- fifo_afull=1 while requester 0 waits in IDLE:
  - No grant and req_ready=0 while afull=1.
  - afull falls -> grant on the next edge.
  - Separately: afull rising mid-packet does not stall the remaining beats.
- fifo_full asserted on beat 2 of a 4-beat packet for 3 cycles:
  - req_ready=0 and fifo_wr_en=0 during those 3 cycles.
  - Beats 2-3 follow once full drops. No beat is lost or duplicated; the scoreboard compares data order.
- Wrap: grant requester 3 (NREQ=4), then requesters 0 and 3 both valid -> requester 0 wins.
  - Repeat with NREQ=3: after requester 2, rr_ptr=0.
- rst_n low for 1 cycle in the middle of a 5-beat packet:
  - Next cycle: state IDLE, busy=0, req_ready=0, pkt_count=0, rr_ptr=0.
  - A resent packet is granted normally.
